// File: rtl/mm_bram_parallel_ctrl_pkg.sv
// Shared types and defaults for the parallel GEMM row-issue controller.
package mm_bram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  localparam int unsigned DEFAULT_SRAM_RD_LAT = 1;

endpackage

// File: rtl/mm_bram_parallel_ctrl_if.sv
// Job control, source SRAM read port, datapath alignment and write-back status.
interface mm_bram_parallel_ctrl_if #(
  parameter int unsigned ROW_NUM = 32
);
  localparam int unsigned ROW_ADDR_WIDTH = $clog2(ROW_NUM);

  logic                      start;
  logic [ROW_ADDR_WIDTH:0]   num_rows;
  logic                      hold;
  logic                      src_rd_en;
  logic [ROW_ADDR_WIDTH-1:0] src_rd_addr;
  logic                      dpath_sum_en;
  logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr;
  logic                      row_wr_en0;
  logic                      busy;
  logic                      done;

  modport master (
    output start, num_rows, hold, row_wr_en0,
    input  src_rd_en, src_rd_addr, dpath_sum_en, dpath_result_wraddr, busy, done
  );

  modport slave (
    input  start, num_rows, hold, row_wr_en0,
    output src_rd_en, src_rd_addr, dpath_sum_en, dpath_result_wraddr, busy, done
  );
endinterface

// File: rtl/mm_bram_parallel_ctrl_delay_line.sv
// Fixed-depth {en, data} shift register; data stages load only with en so the
// delayed data holds its last valid value while en is low.
module mm_ctrl_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_en,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_en;
  logic [WIDTH-1:0] r_data [DEPTH];

  // Shift enable every cycle; advance data only behind a valid enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_en[0] <= i_en;
      if (i_en) r_data[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_en[i] <= r_en[i-1];
        if (r_en[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_en   = r_en[DEPTH-1];
  assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/mm_bram_parallel_ctrl.sv
// Row-issue controller: walks source rows, aligns strobe/address with SRAM
// read data for the datapath, and counts lane-0 write-backs to signal done.
module mm_bram_parallel_ctrl
  import mm_bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ROW_NUM     = 32,
  parameter int unsigned COL_NUM     = 32,
  parameter int unsigned LENGTH      = 32,
  parameter int unsigned SRAM_RD_LAT = DEFAULT_SRAM_RD_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  mm_bram_parallel_ctrl_if.slave  bus
);

  localparam int unsigned ROW_ADDR_WIDTH = $clog2(ROW_NUM);
  localparam int unsigned CW             = ROW_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ROW_NUM_C    = CW'(ROW_NUM);

  if (SRAM_RD_LAT < 1 || ROW_NUM < 2 || DATA_WIDTH < 1 || COL_NUM < 1 || LENGTH < 1) begin : g_param_check
    $error("mm_bram_parallel_ctrl: illegal parameter set");
  end

  ctrl_state_t               r_state, w_state_nxt;
  logic [CW-1:0]             r_n, w_n_nxt;
  logic [CW-1:0]             r_issue_cnt, w_issue_cnt_nxt;
  logic [CW-1:0]             r_wr_cnt, w_wr_cnt_nxt;
  logic [CW-1:0]             w_n_clamped;
  logic [ROW_ADDR_WIDTH-1:0] r_last_addr;
  logic                      w_rd_en;
  logic [ROW_ADDR_WIDTH-1:0] w_rd_addr;
  logic                      w_dp_en;
  logic [ROW_ADDR_WIDTH-1:0] w_dp_addr;

  // Next-state, counter updates and the combinational read strobe.
  always_comb begin
    w_state_nxt     = r_state;
    w_n_nxt         = r_n;
    w_issue_cnt_nxt = r_issue_cnt;
    w_wr_cnt_nxt    = r_wr_cnt;
    w_rd_en         = 1'b0;
    w_n_clamped     = (bus.num_rows > ROW_NUM_C) ? ROW_NUM_C : bus.num_rows;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_n_nxt         = w_n_clamped;
          w_issue_cnt_nxt = '0;
          w_wr_cnt_nxt    = '0;
          w_state_nxt     = (w_n_clamped == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (bus.row_wr_en0) w_wr_cnt_nxt = r_wr_cnt + CW'(1);
        if (!bus.hold) begin
          w_rd_en         = 1'b1;
          w_issue_cnt_nxt = r_issue_cnt + CW'(1);
          if (r_issue_cnt == r_n - CW'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.row_wr_en0) w_wr_cnt_nxt = r_wr_cnt + CW'(1);
        if (w_wr_cnt_nxt == r_n) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address bus shows the live count when reading, otherwise the last issued row.
  assign w_rd_addr = w_rd_en ? r_issue_cnt[ROW_ADDR_WIDTH-1:0] : r_last_addr;

  // State, job length, counters and last-issued address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
      r_last_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_n         <= w_n_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      if (w_rd_en) r_last_addr <= r_issue_cnt[ROW_ADDR_WIDTH-1:0];
    end
  end

  mm_ctrl_delay_line #(
    .DEPTH (SRAM_RD_LAT),
    .WIDTH (ROW_ADDR_WIDTH)
  ) u_delay (
    .clk    (clk),
    .rst    (reset),
    .i_en   (w_rd_en),
    .i_data (w_rd_addr),
    .o_en   (w_dp_en),
    .o_data (w_dp_addr)
  );

  assign bus.src_rd_en           = w_rd_en;
  assign bus.src_rd_addr         = w_rd_addr;
  assign bus.dpath_sum_en        = w_dp_en;
  assign bus.dpath_result_wraddr = w_dp_addr;
  assign bus.busy                = (r_state == ISSUE) || (r_state == DRAIN);
  assign bus.done                = (r_state == DONE);

endmodule

// File: tb/tb_mm_bram_parallel_ctrl.sv
// Scoreboard bench for mm_bram_parallel_ctrl with a fixed-latency lane-0 model.
module tb_mm_bram_parallel_ctrl;

  localparam int ROW_NUM = 32;
  localparam int AW      = $clog2(ROW_NUM);
  localparam int NW      = AW + 1;
  localparam int LAT     = 1;
  localparam int P       = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [AW-1:0] m_last_addr = '0;
  logic [AW-1:0] m_dp_last   = '0;
  logic [AW-1:0] q_rd [$];
  logic [AW-1:0] q_dp [$];

  always #5 clk = ~clk;

  mm_bram_parallel_ctrl_if #(.ROW_NUM(ROW_NUM)) bus ();

  mm_bram_parallel_ctrl #(
    .DATA_WIDTH  (8),
    .ROW_NUM     (ROW_NUM),
    .COL_NUM     (32),
    .LENGTH      (32),
    .SRAM_RD_LAT (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.num_rows = '0; bus.hold = 1'b0; bus.row_wr_en0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.src_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b exp 0", bus.src_rd_en); end
    n_cmp++; if (bus.src_rd_addr !== '0) begin n_err++; $display("FAIL reset_rd_addr got %0d exp 0", bus.src_rd_addr); end
    n_cmp++; if (bus.dpath_sum_en !== 1'b0) begin n_err++; $display("FAIL reset_sum_en got %b exp 0", bus.dpath_sum_en); end
    n_cmp++; if (bus.dpath_result_wraddr !== '0) begin n_err++; $display("FAIL reset_wraddr got %0d exp 0", bus.dpath_result_wraddr); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bus.done); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Runs one job to completion, checking every cycle against the scoreboard.
  task automatic run_job(input int n_req, input int hold_after, input int hold_len,
                         input bit start_mid, input bit start_in_done, input string tag);
    int n_eff, issued, completed, cyc, hold_left, exp_cyc;
    bit hold_used, issuing, active, done_next, exp_done, exp_rd_en, prev_rd_en, done_seen;
    logic [AW-1:0] e;
    logic [7:0] dp_sr;
    n_eff = (n_req > ROW_NUM) ? ROW_NUM : n_req;
    issued = 0; completed = 0; cyc = 0; hold_left = 0; hold_used = 0;
    prev_rd_en = 0; done_seen = 0; dp_sr = '0;
    q_rd.delete(); q_dp.delete();
    for (int k = 0; k < n_eff; k++) begin
      q_rd.push_back(AW'(k));
      q_dp.push_back(AW'(k));
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_rows = NW'(n_req); bus.hold = 1'b0; bus.row_wr_en0 = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.src_rd_en !== 1'b0) begin n_err++; $display("FAIL %s start_cycle_rd_en got %b exp 0", tag, bus.src_rd_en); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL %s start_cycle_busy got %b exp 0", tag, bus.busy); end
    issuing = (n_eff > 0); active = issuing; done_next = (n_eff == 0);
    while (!done_seen && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (start_mid && issuing && issued == 1) begin bus.start = 1'b1; bus.num_rows = NW'(7); end
      if (start_in_done && done_next) begin bus.start = 1'b1; bus.num_rows = NW'(5); end
      if (issuing && !hold_used && issued == hold_after) begin hold_left = hold_len; hold_used = 1; end
      bus.hold = (hold_left > 0);
      bus.row_wr_en0 = dp_sr[P-1];
      if (bus.row_wr_en0) completed++;
      @(negedge clk);
      exp_done = done_next;
      if (exp_done) active = 0;
      exp_rd_en = issuing && !bus.hold;
      n_cmp++; if (bus.done !== exp_done) begin n_err++; $display("FAIL %s done cyc %0d got %b exp %b", tag, cyc, bus.done, exp_done); end
      n_cmp++; if (bus.busy !== active) begin n_err++; $display("FAIL %s busy cyc %0d got %b exp %b", tag, cyc, bus.busy, active); end
      n_cmp++; if (bus.src_rd_en !== exp_rd_en) begin n_err++; $display("FAIL %s rd_en cyc %0d got %b exp %b", tag, cyc, bus.src_rd_en, exp_rd_en); end
      if (exp_rd_en) begin
        e = (q_rd.size() > 0) ? q_rd.pop_front() : '0;
        m_last_addr = e;
        issued++;
        if (issued == n_eff) issuing = 0;
      end
      n_cmp++; if (bus.src_rd_addr !== m_last_addr) begin n_err++; $display("FAIL %s rd_addr cyc %0d got %0d exp %0d", tag, cyc, bus.src_rd_addr, m_last_addr); end
      n_cmp++; if (bus.dpath_sum_en !== prev_rd_en) begin n_err++; $display("FAIL %s sum_en cyc %0d got %b exp %b", tag, cyc, bus.dpath_sum_en, prev_rd_en); end
      if (prev_rd_en) m_dp_last = (q_dp.size() > 0) ? q_dp.pop_front() : '0;
      n_cmp++; if (bus.dpath_result_wraddr !== m_dp_last) begin n_err++; $display("FAIL %s wraddr cyc %0d got %0d exp %0d", tag, cyc, bus.dpath_result_wraddr, m_dp_last); end
      prev_rd_en = exp_rd_en;
      dp_sr = {dp_sr[6:0], bus.dpath_sum_en};
      done_next = bus.row_wr_en0 && (completed == n_eff);
      if (hold_left > 0) hold_left--;
      if (exp_done) done_seen = 1;
    end
    exp_cyc = (n_eff == 0) ? 1 : 1 + n_eff + LAT + P + (hold_used ? hold_len : 0);
    n_cmp++; if (!done_seen) begin n_err++; $display("FAIL %s timeout got no done after %0d cycles exp done", tag, cyc); end
    n_cmp++; if (cyc != exp_cyc) begin n_err++; $display("FAIL %s latency got %0d exp %0d", tag, cyc, exp_cyc); end
    n_cmp++; if (issued != n_eff || q_rd.size() != 0) begin n_err++; $display("FAIL %s read_count got %0d exp %0d", tag, issued, n_eff); end
    n_cmp++; if (q_dp.size() != 0) begin n_err++; $display("FAIL %s dpath_left got %0d exp 0", tag, q_dp.size()); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hold = 1'b0; bus.row_wr_en0 = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL %s post_done got %b exp 0", tag, bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL %s post_busy got %b exp 0", tag, bus.busy); end
    n_cmp++; if (bus.src_rd_en !== 1'b0) begin n_err++; $display("FAIL %s post_rd_en got %b exp 0", tag, bus.src_rd_en); end
  endtask

  task automatic test_basic();
    run_job(4, -1, 0, 1'b0, 1'b0, "basic4");
  endtask

  task automatic test_zero_rows();
    run_job(0, -1, 0, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_hold();
    run_job(6, 2, 3, 1'b0, 1'b0, "hold6");
  endtask

  task automatic test_clamp();
    run_job(40, -1, 0, 1'b0, 1'b0, "clamp40");
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_rows = NW'(8); bus.hold = 1'b0; bus.row_wr_en0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.src_rd_en !== 1'b1 || bus.src_rd_addr !== AW'(k)) begin n_err++; $display("FAIL midrst_issue%0d got en=%b addr=%0d exp en=1 addr=%0d", k, bus.src_rd_en, bus.src_rd_addr, k); end
    end
    @(posedge clk); #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.src_rd_en !== 1'b0 || bus.src_rd_addr !== '0) begin n_err++; $display("FAIL midrst_rd got en=%b addr=%0d exp 0/0", bus.src_rd_en, bus.src_rd_addr); end
    n_cmp++; if (bus.dpath_sum_en !== 1'b0 || bus.dpath_result_wraddr !== '0) begin n_err++; $display("FAIL midrst_dpath got en=%b addr=%0d exp 0/0", bus.dpath_sum_en, bus.dpath_result_wraddr); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_status got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
    m_last_addr = '0; m_dp_last = '0;
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 bus.row_wr_en0 = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.src_rd_en !== 1'b0) begin n_err++; $display("FAIL midrst_stray%0d got busy=%b done=%b rd=%b exp 0/0/0", k, bus.busy, bus.done, bus.src_rd_en); end
    end
    @(posedge clk); #1 bus.row_wr_en0 = 1'b0;
    run_job(2, -1, 0, 1'b0, 1'b0, "after_reset2");
  endtask

  task automatic test_ignored_start();
    run_job(5, -1, 0, 1'b1, 1'b1, "ignored_start5");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_rows();
    test_hold();
    test_clamp();
    test_mid_reset();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mm_bram_parallel_ctrl.md
Name: mm_bram_parallel_ctrl

Overview:
Row-issue controller directly upstream of the parallel GEMM datapath. On a start pulse it walks source SRAM row addresses 0..num_rows-1 and issues one read per cycle. It delays the read strobe and address by the SRAM read latency, so dpath_sum_en and dpath_result_wraddr arrive cycle-aligned with row_data_in at the datapath. It counts write-backs returning on datapath lane 0 and raises done once every issued row has been written to the result SRAM.

Parameters:
DATA_WIDTH, 8, element width; passed through only, for consistency with the datapath
ROW_NUM, 32, maximum rows per job (depth of source and result SRAM)
COL_NUM, 32, datapath column count; informational
LENGTH, 32, dot-product length; informational
SRAM_RD_LAT, 1, source SRAM read latency in cycles (>=1)
ROW_ADDR_WIDTH, $clog2(ROW_NUM), derived; not set manually

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  single-cycle job start; sampled only in IDLE
num_rows  in  ROW_ADDR_WIDTH+1  rows in job; latched on accepted start
hold  in  1  issue stall; while high no new read is issued
src_rd_en  out  1  source SRAM read enable
src_rd_addr  out  ROW_ADDR_WIDTH  source SRAM read address
dpath_sum_en  out  1  to datapath; src_rd_en delayed by SRAM_RD_LAT
dpath_result_wraddr  out  ROW_ADDR_WIDTH  to datapath; src_rd_addr delayed by SRAM_RD_LAT
row_wr_en0  in  1  datapath lane-0 write valid (one pulse per completed row)
busy  out  1  high in ISSUE and DRAIN
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (async, active-high): state=IDLE. issue_cnt, wr_cnt, the latched row count and the whole delay line clear to 0. All outputs are 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches n = min(num_rows, ROW_NUM) and clears both counters.
  - If n==0, next state is DONE. Otherwise next state is ISSUE.
  - start is ignored in every other state.
- ISSUE:
  - Each cycle with hold=0: src_rd_en=1, src_rd_addr=issue_cnt, then issue_cnt+1.
  - With hold=1: src_rd_en=0, and src_rd_addr holds its last value.
  - The cycle that issues address n-1 moves the FSM to DRAIN.
  - src_rd_en/src_rd_addr are combinational from state and issue_cnt, so the first read appears in the cycle after start.
- Delay line:
  - SRAM_RD_LAT registered stages carry {en, addr}.
  - dpath_sum_en(t) = src_rd_en(t-SRAM_RD_LAT); dpath_result_wraddr follows the same rule.
  - The addr stage captures only when en=1, so the address is stable while en=0.
- wr_cnt:
  - Increments on row_wr_en0 in ISSUE or DRAIN; completions may overlap issue.
  - row_wr_en0 in IDLE or DONE is ignored. This covers stale results after a mid-job reset.
- DRAIN: when wr_cnt == n, including the cycle a final pulse arrives, next state is DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start asserted in the DONE cycle is dropped.
- Counters are ROW_ADDR_WIDTH+1 bits wide, so n=ROW_NUM does not wrap. issue_cnt never exceeds n-1 on the address bus.
- Latency: with zero hold and datapath latency P, done rises at start + 1 + n + SRAM_RD_LAT + P cycles.

Decomposition:
- Shared package mm_bram_pkg holds:
  - ctrl_state_t enum {IDLE, ISSUE, DRAIN, DONE};
  - the localparam for the default SRAM_RD_LAT.
- One sub-module, mm_ctrl_delay_line: parameterised depth/width shift register with async reset, used for the {en, addr} alignment.

Test Plan:
1. num_rows=4, SRAM_RD_LAT=1, hold=0:
   - src_rd_addr 0,1,2,3 issued on cycles 1-4 after start;
   - dpath_sum_en high on cycles 2-5 with wraddr 0..3;
   - done pulses 1 cycle after the 4th row_wr_en0.
2. num_rows=0 → done pulses the cycle after start; src_rd_en never asserts; busy never asserts.
3. num_rows=6, hold high for 3 cycles after the 2nd issue:
   - addresses 0,1 issued, then a gap, then 2..5;
   - dpath_result_wraddr holds at 1 during the gap;
   - done follows the 6th completion.
4. num_rows=40 with ROW_NUM=32 → exactly 32 reads (addr 0..31), with no wrap back to address 0.
5. Reset asserted mid-ISSUE (after 3 issues):
   - all outputs go to 0 immediately;
   - stray row_wr_en0 pulses afterwards are ignored;
   - a new start with num_rows=2 completes normally.
6. start pulsed during ISSUE and again in the DONE cycle → both are ignored; the job count and addresses are unchanged.
